// File: rtl/vproc_evl_seq_if.sv
// vproc_evl_seq_if: instruction-in and operand-part-out handshake bundle of the EVL sequencer.
interface vproc_evl_seq_if #(
    parameter int VREG_W = 128,
    parameter int OP_W   = 32
);
    localparam int VLW  = $clog2(VREG_W) + 1;
    localparam int OFFW = (VREG_W / OP_W > 1) ? $clog2(VREG_W / OP_W) : 1;
    localparam int BEW  = OP_W / 8;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [1:0]      eew_i;
    logic [1:0]      emul_i;
    logic [VLW-1:0]  vl_i;
    logic [1:0]      policy_i;
    logic [4:0]      vbase_i;
    logic            op_valid_o;
    logic            op_ready_i;
    logic [4:0]      op_vaddr_o;
    logic [OFFW-1:0] op_off_o;
    logic [BEW-1:0]  op_be_o;
    logic            op_first_o;
    logic            op_last_o;
    modport master (
        input  in_valid_i, eew_i, emul_i, vl_i, policy_i, vbase_i, op_ready_i,
        output in_ready_o, op_valid_o, op_vaddr_o, op_off_o, op_be_o, op_first_o, op_last_o
    );
    modport slave (
        output in_valid_i, eew_i, emul_i, vl_i, policy_i, vbase_i, op_ready_i,
        input  in_ready_o, op_valid_o, op_vaddr_o, op_off_o, op_be_o, op_first_o, op_last_o
    );
endinterface

// File: rtl/vproc_evl_seq.sv
// vproc_evl_seq: turns one decoded vector instruction into a stream of operand-part requests
// covering the register group, with byte enables clipped to the effective vector length.
module vproc_evl_seq #(
    parameter int VREG_W = 128,
    parameter int OP_W   = 32,
    parameter int ELEN   = 32
) (
    input  logic clk_i,
    input  logic sync_rst_i,
    input  logic flush_i,
    output logic err_o,
    vproc_evl_seq_if.master bus
);
    localparam int PPR  = VREG_W / OP_W;
    localparam int PPRL = $clog2(PPR);
    localparam int OBL  = $clog2(OP_W / 8);
    localparam int OFFW = (PPR > 1) ? PPRL : 1;
    localparam int BEW  = OP_W / 8;
    localparam int EW   = $clog2(VREG_W) + 4;
    localparam int KW   = PPRL + 3;
    localparam logic [1:0] POL_DEFAULT = 2'd0;
    localparam logic [1:0] POL_ONE     = 2'd1;
    localparam logic [1:0] POL_MASK    = 2'd2;

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q;
    logic [EW-1:0]   evl_q;
    logic [4:0]      vbase_q;
    logic [KW-1:0]   k_q, last_q;
    logic            op_valid_q, op_first_q, op_last_q, err_q;
    logic [4:0]      op_vaddr_q;
    logic [OFFW-1:0] op_off_q;
    logic [BEW-1:0]  op_be_q;

    logic            acc, adv, legal;
    logic [EW-1:0]   evl_max, evl_raw, evl_new, p_evl, p_base;
    logic [KW-1:0]   last_new, p_k, p_last;
    logic [4:0]      p_vbase, p_vaddr;
    logic [OFFW-1:0] p_off;
    logic [BEW-1:0]  p_be;

    assign adv            = op_valid_q & bus.op_ready_i;
    assign bus.in_ready_o = ((state_q == IDLE) | (adv & op_last_q)) & ~flush_i;
    assign acc            = bus.in_valid_i & bus.in_ready_o;
    assign legal          = (bus.eew_i != 2'b11 || ELEN == 64) &&
                            ((bus.vbase_i & ~(5'h1f << bus.emul_i)) == 5'd0);

    // EVL in bytes and index of the final part, both fixed at accept time
    always_comb begin
        evl_max  = EW'(VREG_W / 8) << bus.emul_i;
        evl_raw  = (bus.policy_i == POL_DEFAULT) ? EW'(bus.vl_i) << bus.eew_i :
                   (bus.policy_i == POL_ONE)     ? EW'(1) << bus.eew_i :
                   (bus.policy_i == POL_MASK)    ? (EW'(bus.vl_i) + EW'(7)) >> 3 : evl_max;
        evl_new  = (evl_raw > evl_max) ? evl_max : evl_raw;
        last_new = (evl_new == '0) ? '0 : KW'((evl_new - EW'(1)) >> OBL);
    end

    // Fields of the part to present next: part 0 of a new instruction or the successor of k_q
    always_comb begin
        p_k     = acc ? '0 : k_q + KW'(1);
        p_evl   = acc ? evl_new : evl_q;
        p_vbase = acc ? bus.vbase_i : vbase_q;
        p_last  = acc ? last_new : last_q;
        p_base  = EW'(p_k) << OBL;
        p_vaddr = p_vbase + 5'(p_k >> PPRL);
        p_off   = OFFW'(p_k & KW'(PPR - 1));
        p_be    = '0;
        for (int b = 0; b < BEW; b++)
            p_be[b] = (p_base + EW'(b)) < p_evl;
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q    <= IDLE;
            evl_q      <= '0;
            vbase_q    <= '0;
            k_q        <= '0;
            last_q     <= '0;
            op_valid_q <= 1'b0;
            op_vaddr_q <= '0;
            op_off_q   <= '0;
            op_be_q    <= '0;
            op_first_q <= 1'b0;
            op_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else if (flush_i) begin
            state_q    <= IDLE;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= acc & ~legal;
            if ((acc & legal) | (adv & ~op_last_q)) begin
                state_q    <= RUN;
                op_valid_q <= 1'b1;
                k_q        <= p_k;
                evl_q      <= p_evl;
                vbase_q    <= p_vbase;
                last_q     <= p_last;
                op_vaddr_q <= p_vaddr;
                op_off_q   <= p_off;
                op_be_q    <= p_be;
                op_first_q <= (p_k == '0);
                op_last_q  <= (p_k == p_last);
            end else if (adv) begin
                state_q    <= IDLE;
                op_valid_q <= 1'b0;
            end
        end
    end

    assign bus.op_valid_o = op_valid_q;
    assign bus.op_vaddr_o = op_vaddr_q;
    assign bus.op_off_o   = op_off_q;
    assign bus.op_be_o    = op_be_q;
    assign bus.op_first_o = op_first_q;
    assign bus.op_last_o  = op_last_q;
    assign err_o          = err_q;
endmodule

// File: tb/tb_vproc_evl_seq.sv
// tb_vproc_evl_seq: drives ELEN=32 and ELEN=64 sequencers in lockstep and compares every cycle
// against a queue of expected parts built from the EVL rules.
module tb_vproc_evl_seq;
    localparam int VREG_W = 128;
    localparam int OP_W   = 32;
    localparam int OB     = OP_W / 8;
    localparam int PPR    = VREG_W / OP_W;
    localparam int RB     = VREG_W / 8;

    typedef struct {
        logic [4:0] va;
        logic [1:0] off;
        logic [3:0] be;
        logic       first;
        logic       last;
    } part_t;
    typedef part_t pq_t[$];

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, rdy = 1'b0;
    logic v32 = 1'b0, v64 = 1'b0;
    logic [1:0] eew = '0, emul = '0, pol = '0;
    logic [7:0] vl = '0;
    logic [4:0] vb = '0;
    logic err32, err64;
    pq_t q32, q64;
    bit e32, e64;
    int checks = 0, fails = 0, mode = 0;

    always #5 clk = ~clk;

    vproc_evl_seq_if #(.VREG_W(VREG_W), .OP_W(OP_W)) b32 ();
    vproc_evl_seq_if #(.VREG_W(VREG_W), .OP_W(OP_W)) b64 ();

    assign b32.in_valid_i = v32;
    assign b64.in_valid_i = v64;
    assign b32.eew_i = eew;   assign b64.eew_i = eew;
    assign b32.emul_i = emul; assign b64.emul_i = emul;
    assign b32.vl_i = vl;     assign b64.vl_i = vl;
    assign b32.policy_i = pol; assign b64.policy_i = pol;
    assign b32.vbase_i = vb;  assign b64.vbase_i = vb;
    assign b32.op_ready_i = rdy; assign b64.op_ready_i = rdy;

    vproc_evl_seq #(.VREG_W(VREG_W), .OP_W(OP_W), .ELEN(32)) u32 (
        .clk_i(clk), .sync_rst_i(rst), .flush_i(flush), .err_o(err32), .bus(b32.master));
    vproc_evl_seq #(.VREG_W(VREG_W), .OP_W(OP_W), .ELEN(64)) u64 (
        .clk_i(clk), .sync_rst_i(rst), .flush_i(flush), .err_o(err64), .bus(b64.master));

    function automatic bit legal_f(int elen, int e, int m, int vbase);
        return !(e == 3 && elen == 32) && (vbase % (1 << m) == 0);
    endfunction

    function automatic pq_t gen(int e, int m, int vlen, int p, int vbase);
        pq_t q;
        part_t t;
        int eb = 1 << e;
        int mx = (1 << m) * RB;
        int evl = (p == 0) ? vlen * eb : (p == 1) ? eb : (p == 2) ? (vlen + 7) / 8 : mx;
        int n;
        if (evl > mx) evl = mx;
        n = (evl == 0) ? 1 : (evl + OB - 1) / OB;
        for (int k = 0; k < n; k++) begin
            t.va = 5'(vbase + k / PPR);
            t.off = 2'(k % PPR);
            for (int b = 0; b < OB; b++) t.be[b] = (k * OB + b < evl);
            t.first = (k == 0);
            t.last = (k == n - 1);
            q.push_back(t);
        end
        return q;
    endfunction

    function automatic bit rdy_f(pq_t q);
        return (q.size() == 0 || (rdy && q.size() == 1)) && !flush;
    endfunction

    function automatic pq_t nxt(pq_t q, bit acc, int elen);
        pq_t r = q;
        pq_t g;
        if (rst || flush) begin
            r.delete();
        end else begin
            if (r.size() != 0 && rdy) void'(r.pop_front());
            if (acc && legal_f(elen, eew, emul, vb)) begin
                g = gen(eew, emul, vl, pol, vb);
                foreach (g[i]) r.push_back(g[i]);
            end
        end
        return r;
    endfunction

    task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_inst(string n, pq_t q, bit e, logic g_rdy, logic g_val, logic [4:0] g_va,
                            logic [1:0] g_off, logic [3:0] g_be, logic g_f, logic g_l, logic g_err);
        cmp({n, ".in_ready"}, g_rdy, rdy_f(q));
        cmp({n, ".op_valid"}, g_val, q.size() != 0);
        cmp({n, ".err"}, g_err, e);
        if (q.size() != 0) begin
            cmp({n, ".vaddr"}, g_va, q[0].va);
            cmp({n, ".off"}, g_off, q[0].off);
            cmp({n, ".be"}, g_be, q[0].be);
            cmp({n, ".first"}, g_f, q[0].first);
            cmp({n, ".last"}, g_l, q[0].last);
        end
    endtask

    task automatic step();
        bit a32, a64;
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ~rdy : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        chk_inst("elen32", q32, e32, b32.in_ready_o, b32.op_valid_o, b32.op_vaddr_o, b32.op_off_o,
                 b32.op_be_o, b32.op_first_o, b32.op_last_o, err32);
        chk_inst("elen64", q64, e64, b64.in_ready_o, b64.op_valid_o, b64.op_vaddr_o, b64.op_off_o,
                 b64.op_be_o, b64.op_first_o, b64.op_last_o, err64);
        a32 = v32 && rdy_f(q32);
        a64 = v64 && rdy_f(q64);
        @(posedge clk);
        e32 = !rst && !flush && a32 && !legal_f(32, eew, emul, vb);
        e64 = !rst && !flush && a64 && !legal_f(64, eew, emul, vb);
        q32 = nxt(q32, a32, 32);
        q64 = nxt(q64, a64, 64);
        #1;
        if (a32) v32 = 1'b0;
        if (a64) v64 = 1'b0;
    endtask

    task automatic issue(int e, int m, int vlen, int p, int vbase);
        eew = 2'(e); emul = 2'(m); vl = 8'(vlen); pol = 2'(p); vb = 5'(vbase);
        v32 = 1'b1; v64 = 1'b1;
        for (int i = 0; i < 300 && (v32 || v64); i++) step();
        checks++;
        assert (!(v32 || v64)) else begin
            fails++;
            $error("FAIL accept_timeout got=pending exp=accepted");
        end
        v32 = 1'b0; v64 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q32.size() != 0 || q64.size() != 0 || e32 || e64); i++) step();
        checks++;
        assert (q32.size() == 0 && q64.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout got=%0d/%0d exp=0/0", q32.size(), q64.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step();
        cmp("rst.vaddr", b32.op_vaddr_o, 0);
        cmp("rst.off", b32.op_off_o, 0);
        cmp("rst.be", b64.op_be_o, 0);
        cmp("rst.first", b64.op_first_o, 0);
        cmp("rst.last", b64.op_last_o, 0);
        rst = 1'b0;
        step();
        // directed cases
        mode = 0;
        issue(0, 0, 10, 0, 4); drain();
        issue(3, 1, 3, 0, 6); drain();
        mode = 1;
        issue(0, 3, 0, 3, 8); drain();
        mode = 0;
        issue(0, 0, 0, 0, 4); drain();
        issue(3, 0, 5, 0, 0); drain();
        issue(0, 2, 4, 0, 2); drain();
        issue(2, 0, 9, 1, 3); drain();
        issue(0, 1, 77, 2, 10); drain();
        issue(1, 0, 4, 0, 2);
        issue(0, 1, 20, 0, 2); drain();
        // flush at part 2 of 8 with a competing instruction offered the same cycle
        issue(2, 1, 8, 0, 0);
        step(); step();
        flush = 1'b1; eew = 2'd0; emul = 2'd0; vl = 8'd4; vb = 5'd0; v32 = 1'b1; v64 = 1'b1;
        step();
        flush = 1'b0; v32 = 1'b0; v64 = 1'b0;
        step(); step();
        // synchronous reset at part 2 of 8
        issue(2, 1, 8, 0, 0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(); step();
        // randomized instructions with random consumer stalls
        mode = 2;
        for (int i = 0; i < 60; i++) begin
            int m = $urandom_range(0, 3);
            int vbase = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                                    : (($urandom_range(0, 31) >> m) << m);
            issue($urandom_range(0, 3), m, $urandom_range(0, 128), $urandom_range(0, 3), vbase);
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
